stream_demux4: RTL and testbench

- 1-to-4 streaming demultiplexer with valid/ready handshakes; the routing counterpart of the 4:1 datapath mux.
- Steers one input stream to one of four output channels, selected per beat by `in_sel`.
- Each output channel has a one-entry registered slot, so a stalled channel does not block beats bound for other channels.
- Used wherever a single producer feeds four consumers, e.g. writeback or response fan-out.

---
 rtl/stream_demux4_pkg.sv | 9 +
 rtl/stream_demux4_if.sv | 27 ++
 rtl/stream_demux4_slot.sv | 37 +++
 rtl/stream_demux4.sv | 32 +++
 tb/tb_stream_demux4.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux4_pkg.sv
// stream_demux4_pkg: shared channel count, select type and out_data slice helper
package stream_demux4_pkg;
    localparam int NUM_CH = 4;
    typedef logic [1:0] ch_sel_t;
    // Low bit of channel k's slice within the packed out_data bus.
    function automatic int slice_lo(input int k, input int dw);
        return k * dw;
    endfunction
endpackage

// File: rtl/stream_demux4_if.sv
// stream_demux4_if: input stream plus four output channels for the 1:4 demux
//   in_valid/in_ready/in_data/in_sel : producer side, in_sel picks the channel
//   out_valid/out_ready/out_data     : per-channel consumer side, slice k = channel k
//   busy                             : any output slot holds a beat
//   master = producer/consumers, slave = demux
interface stream_demux4_if
    import stream_demux4_pkg::*;
#(
    parameter int DW = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    ch_sel_t              in_sel;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH-1:0]    out_ready;
    logic [NUM_CH*DW-1:0] out_data;
    logic                 busy;
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/stream_demux4_slot.sv
// demux_slot: one-entry registered output slot with fill and drain
//   clk, rst : clock, async active-high reset
//   fill_i   : load data_i this edge
//   ready_i  : consumer ready for the held beat
//   data_i   : incoming payload
//   valid_o  : slot holds a beat
//   data_o   : held payload (keeps last value when empty)
module demux_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill_i,
    input  logic          ready_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    // A fill wins over a drain, so drain+fill keeps the slot full with new data.
    always_comb begin
        valid_d = fill_i || (valid_q && !ready_i);
        data_d  = fill_i ? data_i : data_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/stream_demux4.sv
// stream_demux4: 1-to-4 valid/ready stream demux with one registered slot per channel
//   clk, rst : clock, async active-high reset
//   bus      : stream_demux4_if slave (input stream, four output channels, busy)
module stream_demux4
    import stream_demux4_pkg::*;
#(
    parameter int DW = 32
) (
    input logic            clk,
    input logic            rst,
    stream_demux4_if.slave bus
);
    logic [NUM_CH-1:0] fill_en;
    // in_ready only looks at the selected slot, so a stalled channel never
    // blocks beats bound elsewhere; it never depends on in_valid.
    always_comb begin
        bus.in_ready = !rst && (!bus.out_valid[bus.in_sel] || bus.out_ready[bus.in_sel]);
        fill_en      = (bus.in_valid && bus.in_ready) ? NUM_CH'(1) << bus.in_sel : '0;
        bus.busy     = |bus.out_valid;
    end
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        demux_slot #(.DW(DW)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .fill_i (fill_en[k]),
            .ready_i(bus.out_ready[k]),
            .data_i (bus.in_data),
            .valid_o(bus.out_valid[k]),
            .data_o (bus.out_data[slice_lo(k, DW) +: DW])
        );
    end
endmodule

// File: tb/tb_stream_demux4.sv
// tb_stream_demux4: scenario tasks plus a per-channel scoreboard for stream_demux4
module tb_stream_demux4;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    logic last_hs = 1'b0;
    logic [31:0] exp_q[4][$];

    stream_demux4_if #(.DW(32)) bus ();
    stream_demux4 #(.DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] slice(input int k);
        return bus.out_data[k*32 +: 32];
    endfunction

    // Scoreboard: inputs are stable from posedge+1 to the next posedge, so the
    // negedge sees exactly the handshakes that complete at the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
            last_hs = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    n_checks++;
                    if (exp_q[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL drain_ch%0d: got beat %h, required none (nothing outstanding)", k, slice(k));
                    end else begin
                        logic [31:0] e;
                        e = exp_q[k].pop_front();
                        if (slice(k) !== e) begin
                            n_fail++;
                            $display("FAIL drain_ch%0d: got %h, required %h", k, slice(k), e);
                        end
                    end
                end
            end
            last_hs = bus.in_valid && bus.in_ready;
            if (last_hs) exp_q[bus.in_sel].push_back(bus.in_data);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 2'd1, 32'h1234_5678, 4'b0000);
        tick;
        tick;
        n_checks++;
        if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0000", bus.out_valid); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
        n_checks++;
        if (bus.out_data !== 128'd0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", bus.out_data); end
        drive(1'b0, 2'd0, 32'd0, 4'b0000);
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single_route;
        drive(1'b1, 2'd2, 32'hDEAD_BEEF, 4'b0000);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL route_in_ready: got %b, required 1", bus.in_ready); end
        tick;
        drive(1'b0, 2'd0, 32'd0, 4'b0000);
        #1;
        n_checks++;
        if (bus.out_valid !== 4'b0100) begin n_fail++; $display("FAIL route_out_valid: got %b, required 0100", bus.out_valid); end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL route_busy: got %b, required 1", bus.busy); end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if (slice(2) !== 32'hDEAD_BEEF || bus.out_valid !== 4'b0100) begin
                n_fail++;
                $display("FAIL route_hold: got valid=%b data=%h, required valid=0100 data=deadbeef", bus.out_valid, slice(2));
            end
        end
        bus.out_ready = 4'b0100;
        tick;
        bus.out_ready = 4'b0000;
        #1;
        n_checks++;
        if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL route_drained: got %b, required 0000", bus.out_valid); end
    endtask

    task automatic test_backpressure;
        drive(1'b1, 2'd1, 32'h11, 4'b0000);
        tick;
        drive(1'b1, 2'd1, 32'h44, 4'b0000);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got in_ready=%b, required 0", bus.in_ready); end
        tick;
        drive(1'b1, 2'd3, 32'h33, 4'b0000);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ch: got in_ready=%b, required 1", bus.in_ready); end
        tick;
        drive(1'b0, 2'd0, 32'd0, 4'b0000);
        #1;
        n_checks++;
        if (bus.out_valid !== 4'b1010 || slice(3) !== 32'h33 || slice(1) !== 32'h11) begin
            n_fail++;
            $display("FAIL bp_outputs: got valid=%b s1=%h s3=%h, required 1010 11 33", bus.out_valid, slice(1), slice(3));
        end
        bus.out_ready = 4'b1111;
        tick;
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_drain_fill;
        drive(1'b1, 2'd0, 32'h11, 4'b0000);
        tick;
        drive(1'b1, 2'd0, 32'h22, 4'b0001);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL df_in_ready: got %b, required 1", bus.in_ready); end
        tick;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid[0] !== 1'b1 || slice(0) !== 32'h22) begin
            n_fail++;
            $display("FAIL df_replace: got valid=%b data=%h, required 1 22", bus.out_valid[0], slice(0));
        end
        tick;
        bus.out_ready = 4'b0000;
        #1;
        n_checks++;
        if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL df_empty: got %b, required 0000", bus.out_valid); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'(i % 4), 32'(i), 4'b1111);
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready beat %0d: got %b, required 1", i, bus.in_ready); end
            tick;
            n_checks++;
            if (bus.out_valid[i % 4] !== 1'b1 || slice(i % 4) !== 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_latency beat %0d: got valid=%b data=%h, required 1 %h", i, bus.out_valid[i % 4], slice(i % 4), 32'(i));
            end
        end
        bus.in_valid = 1'b0;
        tick;
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_reset_midflight;
        drive(1'b1, 2'd0, 32'hA0, 4'b0000);
        tick;
        drive(1'b1, 2'd2, 32'hA2, 4'b0000);
        tick;
        drive(1'b0, 2'd0, 32'd0, 4'b0000);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got valid=%b busy=%b, required 0000 0", bus.out_valid, bus.busy);
        end
        tick;
        rst = 1'b0;
        bus.out_ready = 4'b1111;
        tick;
        tick;
        tick;
        n_checks++;
        if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL midreset_no_reappear: got %b, required 0000", bus.out_valid); end
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_random;
        int left;
        for (int c = 0; c < 10000; c++) begin
            // Hold a stalled beat so data and sel stay stable until accepted.
            if (!(bus.in_valid && !last_hs)) begin
                bus.in_valid = ($urandom_range(9) < 7);
                bus.in_sel   = 2'($urandom_range(3));
                bus.in_data  = $urandom;
            end
            bus.out_ready = 4'($urandom_range(15));
            tick;
        end
        drive(1'b0, 2'd0, 32'd0, 4'b1111);
        tick;
        tick;
        left = 0;
        for (int k = 0; k < 4; k++) left += exp_q[k].size();
        n_checks++;
        if (left != 0 || bus.out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL random_final: got %0d outstanding, valid=%b, required 0 outstanding, valid=0000", left, bus.out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_single_route;
        test_backpressure;
        test_drain_fill;
        test_back_to_back;
        test_reset_midflight;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
